// File: rtl/frogger_qsys_otg_hpi_ctrl.sv
// Avalon-MM slave that turns each read/write into one fully timed CY7C67200 HPI bus cycle
// (setup, strobe, hold, recover), with every chip-facing pin driven from a flop.
module frogger_qsys_otg_hpi_ctrl #(
    parameter int SETUP_CYCLES   = 2,
    parameter int STROBE_CYCLES  = 4,
    parameter int HOLD_CYCLES    = 2,
    parameter int RECOVER_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        read_n,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        waitrequest,
    output logic        busy,
    output logic [1:0]  otg_hpi_address,
    output logic        otg_hpi_cs_n,
    output logic        otg_hpi_r_n,
    output logic        otg_hpi_w_n,
    output logic [15:0] otg_hpi_data_out,
    output logic        otg_hpi_data_oe,
    input  logic [15:0] otg_hpi_data_in
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SETUP   = 3'd1;
    localparam logic [2:0] ST_STROBE  = 3'd2;
    localparam logic [2:0] ST_HOLD    = 3'd3;
    localparam logic [2:0] ST_RECOVER = 3'd4;

    // Each phase counter is loaded with N-1 on entry and the phase ends when it reads zero.
    localparam logic [3:0] LD_SETUP   = 4'(SETUP_CYCLES - 1);
    localparam logic [3:0] LD_STROBE  = 4'(STROBE_CYCLES - 1);
    localparam logic [3:0] LD_HOLD    = 4'(HOLD_CYCLES - 1);
    localparam logic [3:0] LD_RECOVER = 4'(RECOVER_CYCLES - 1);

    logic [2:0]  r_state;
    logic [2:0]  w_state_nxt;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nxt;
    logic        r_is_write;
    logic        r_cs_n;
    logic        r_r_n;
    logic        r_w_n;
    logic        r_oe;
    logic        r_busy;
    logic [1:0]  r_addr;
    logic [15:0] r_dout;
    logic [15:0] r_rdata;

    logic        w_req;
    logic        w_req_write;
    logic        w_accept;
    logic        w_cnt_zero;
    logic        w_dir_nxt;
    logic        w_cs_nxt;
    logic        w_strobe_nxt;
    logic        w_capture;
    logic        w_unused_wdata_hi;

    assign w_req       = chipselect & (~read_n | ~write_n);
    assign w_req_write = ~write_n;
    assign w_accept    = (r_state == ST_IDLE) & w_req;
    assign w_cnt_zero  = (r_cnt == 4'd0);
    assign w_unused_wdata_hi = ^writedata[31:16];

    // Next-state and phase-counter logic.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    w_state_nxt = ST_SETUP;
                    w_cnt_nxt   = LD_SETUP;
                end else begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = 4'd0;
                end
            end
            ST_SETUP: begin
                if (w_cnt_zero) begin
                    w_state_nxt = ST_STROBE;
                    w_cnt_nxt   = LD_STROBE;
                end else begin
                    w_state_nxt = ST_SETUP;
                    w_cnt_nxt   = r_cnt - 4'd1;
                end
            end
            ST_STROBE: begin
                if (w_cnt_zero) begin
                    w_state_nxt = ST_HOLD;
                    w_cnt_nxt   = LD_HOLD;
                end else begin
                    w_state_nxt = ST_STROBE;
                    w_cnt_nxt   = r_cnt - 4'd1;
                end
            end
            ST_HOLD: begin
                if (w_cnt_zero) begin
                    w_state_nxt = ST_RECOVER;
                    w_cnt_nxt   = LD_RECOVER;
                end else begin
                    w_state_nxt = ST_HOLD;
                    w_cnt_nxt   = r_cnt - 4'd1;
                end
            end
            ST_RECOVER: begin
                if (w_cnt_zero) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = 4'd0;
                end else begin
                    w_state_nxt = ST_RECOVER;
                    w_cnt_nxt   = r_cnt - 4'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    // Pin values are decoded from the next state so the flops show the new phase in its first cycle.
    always_comb begin
        if (w_accept) begin
            w_dir_nxt = w_req_write;
        end else begin
            w_dir_nxt = r_is_write;
        end
        w_cs_nxt     = (w_state_nxt == ST_SETUP) | (w_state_nxt == ST_STROBE) | (w_state_nxt == ST_HOLD);
        w_strobe_nxt = (w_state_nxt == ST_STROBE);
        w_capture    = (r_state == ST_STROBE) & w_cnt_zero & ~r_is_write;
    end

    // Sequencer state, phase counter and latched transfer direction.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 4'd0;
            r_is_write <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_is_write <= w_dir_nxt;
        end
    end

    // Registered HPI pins and busy flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cs_n <= 1'b1;
            r_r_n  <= 1'b1;
            r_w_n  <= 1'b1;
            r_oe   <= 1'b0;
            r_busy <= 1'b0;
        end else begin
            r_cs_n <= ~w_cs_nxt;
            r_r_n  <= ~(w_strobe_nxt & ~w_dir_nxt);
            r_w_n  <= ~(w_strobe_nxt & w_dir_nxt);
            r_oe   <= w_cs_nxt & w_dir_nxt;
            r_busy <= (w_state_nxt != ST_IDLE);
        end
    end

    // Address and write data are captured once at acceptance and held for the whole bus cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_addr <= 2'd0;
            r_dout <= 16'd0;
        end else begin
            if (w_accept) begin
                r_addr <= address;
            end
            if (w_accept & w_req_write) begin
                r_dout <= writedata[15:0];
            end
        end
    end

    // Read data is sampled on the edge that ends the final strobe cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rdata <= 16'd0;
        end else if (w_capture) begin
            r_rdata <= otg_hpi_data_in;
        end
    end

    // Completion is the last HOLD cycle; the stall is combinational so the master sees it at once.
    assign waitrequest      = w_req & ~((r_state == ST_HOLD) & w_cnt_zero);
    assign readdata         = {16'd0, r_rdata};
    assign busy             = r_busy;
    assign otg_hpi_address  = r_addr;
    assign otg_hpi_cs_n     = r_cs_n;
    assign otg_hpi_r_n      = r_r_n;
    assign otg_hpi_w_n      = r_w_n;
    assign otg_hpi_data_out = r_dout;
    assign otg_hpi_data_oe  = r_oe;

endmodule

// File: tb/tb_frogger_qsys_otg_hpi_ctrl.sv
// Bench for frogger_qsys_otg_hpi_ctrl: two instances (default and all-ones timing) checked
// cycle by cycle against a timeline model built from the setup/strobe/hold/recover lengths.
module tb_frogger_qsys_otg_hpi_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  chipselect;
    logic [1:0]  read_n;
    logic [1:0]  write_n;
    logic [1:0]  waitrequest;
    logic [1:0]  busy;
    logic [1:0]  cs_n;
    logic [1:0]  r_n;
    logic [1:0]  w_n;
    logic [1:0]  oe;
    logic [1:0]  address   [2];
    logic [31:0] writedata [2];
    logic [31:0] readdata  [2];
    logic [1:0]  hpi_addr  [2];
    logic [15:0] dout      [2];
    logic [15:0] din       [2];

    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] model_rdata [2];
    int          sp [2];
    int          pp [2];
    int          hp [2];
    int          rp [2];

    always #5 clk = ~clk;

    frogger_qsys_otg_hpi_ctrl u_dut0 (
        .clk(clk), .reset_n(reset_n), .address(address[0]), .chipselect(chipselect[0]),
        .read_n(read_n[0]), .write_n(write_n[0]), .writedata(writedata[0]),
        .readdata(readdata[0]), .waitrequest(waitrequest[0]), .busy(busy[0]),
        .otg_hpi_address(hpi_addr[0]), .otg_hpi_cs_n(cs_n[0]), .otg_hpi_r_n(r_n[0]),
        .otg_hpi_w_n(w_n[0]), .otg_hpi_data_out(dout[0]), .otg_hpi_data_oe(oe[0]),
        .otg_hpi_data_in(din[0])
    );

    frogger_qsys_otg_hpi_ctrl #(
        .SETUP_CYCLES(1), .STROBE_CYCLES(1), .HOLD_CYCLES(1), .RECOVER_CYCLES(1)
    ) u_dut1 (
        .clk(clk), .reset_n(reset_n), .address(address[1]), .chipselect(chipselect[1]),
        .read_n(read_n[1]), .write_n(write_n[1]), .writedata(writedata[1]),
        .readdata(readdata[1]), .waitrequest(waitrequest[1]), .busy(busy[1]),
        .otg_hpi_address(hpi_addr[1]), .otg_hpi_cs_n(cs_n[1]), .otg_hpi_r_n(r_n[1]),
        .otg_hpi_w_n(w_n[1]), .otg_hpi_data_out(dout[1]), .otg_hpi_data_oe(oe[1]),
        .otg_hpi_data_in(din[1])
    );

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One access on instance d; cycle k=0 is the IDLE cycle where the request is first seen.
    task automatic run_access(input int d, input bit wr, input bit both, input logic [1:0] a,
                              input logic [31:0] wdat, input bit fix_din, input logic [15:0] din_val);
        int          s;
        int          p;
        int          h;
        int          r;
        int          done;
        int          last;
        bit          wr_eff;
        bit          cs_low;
        bit          stb;
        logic [15:0] cap;
        s      = sp[d];
        p      = pp[d];
        h      = hp[d];
        r      = rp[d];
        done   = s + p + h;
        last   = done + r;
        wr_eff = wr | both;
        cap    = model_rdata[d];
        for (int k = 0; k <= last; k++) begin
            @(posedge clk);
            #1;
            if (k == 0) begin
                chipselect[d] = 1'b1;
                address[d]    = a;
                writedata[d]  = wdat;
                if (both) begin
                    read_n[d]  = 1'b0;
                    write_n[d] = 1'b0;
                end else if (wr) begin
                    read_n[d]  = 1'b1;
                    write_n[d] = 1'b0;
                end else begin
                    read_n[d]  = 1'b0;
                    write_n[d] = 1'b1;
                end
            end else if (k == done + 1) begin
                chipselect[d] = 1'b0;
                read_n[d]     = 1'b1;
                write_n[d]    = 1'b1;
                address[d]    = 2'($urandom);
                writedata[d]  = $urandom;
            end
            din[d] = fix_din ? din_val : 16'($urandom);
            if (k == s + p) cap = din[d];
            @(negedge clk);
            cs_low = (k >= 1) && (k <= done);
            stb    = (k >= s + 1) && (k <= s + p);
            chk_eq($sformatf("d%0d k%0d cs_n", d, k), 32'(cs_n[d]), 32'(!cs_low));
            chk_eq($sformatf("d%0d k%0d w_n", d, k), 32'(w_n[d]), 32'(!(stb && wr_eff)));
            chk_eq($sformatf("d%0d k%0d r_n", d, k), 32'(r_n[d]), 32'(!(stb && !wr_eff)));
            chk_eq($sformatf("d%0d k%0d oe", d, k), 32'(oe[d]), 32'(cs_low && wr_eff));
            chk_eq($sformatf("d%0d k%0d busy", d, k), 32'(busy[d]), 32'(k >= 1));
            chk_eq($sformatf("d%0d k%0d waitreq", d, k), 32'(waitrequest[d]), 32'((k <= done) && (k != done)));
            if (cs_low) begin
                chk_eq($sformatf("d%0d k%0d addr", d, k), 32'(hpi_addr[d]), 32'(a));
                if (wr_eff) chk_eq($sformatf("d%0d k%0d dout", d, k), 32'(dout[d]), {16'h0000, wdat[15:0]});
            end
            if (k == 0) chk_eq($sformatf("d%0d k0 readdata", d), readdata[d], {16'h0000, model_rdata[d]});
            if (k == done) chk_eq($sformatf("d%0d done readdata", d), readdata[d],
                                  {16'h0000, (wr_eff ? model_rdata[d] : cap)});
        end
        if (!wr_eff) model_rdata[d] = cap;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                chk_eq($sformatf("d%0d idle cs_n", d), 32'(cs_n[d]), 32'd1);
                chk_eq($sformatf("d%0d idle busy", d), 32'(busy[d]), 32'd0);
                chk_eq($sformatf("d%0d idle waitreq", d), 32'(waitrequest[d]), 32'd0);
                chk_eq($sformatf("d%0d idle oe", d), 32'(oe[d]), 32'd0);
            end
        end
    endtask

    // Start a write on instance 0 and pull reset in its second strobe cycle.
    task automatic reset_mid_strobe();
        for (int k = 0; k <= sp[0] + 2; k++) begin
            @(posedge clk);
            #1;
            if (k == 0) begin
                chipselect[0] = 1'b1;
                address[0]    = 2'd2;
                writedata[0]  = 32'h0000_5A5A;
                read_n[0]     = 1'b1;
                write_n[0]    = 1'b0;
            end
        end
        chk_eq("rst pre w_n", 32'(w_n[0]), 32'd0);
        #2;
        reset_n = 1'b0;
        #1;
        chk_eq("rst w_n", 32'(w_n[0]), 32'd1);
        chk_eq("rst cs_n", 32'(cs_n[0]), 32'd1);
        chk_eq("rst oe", 32'(oe[0]), 32'd0);
        chk_eq("rst busy", 32'(busy[0]), 32'd0);
        chk_eq("rst readdata", readdata[0], 32'd0);
        model_rdata[0] = 16'h0000;
        model_rdata[1] = 16'h0000;
        chipselect[0]  = 1'b0;
        write_n[0]     = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        sp[0] = 2; pp[0] = 4; hp[0] = 2; rp[0] = 2;
        sp[1] = 1; pp[1] = 1; hp[1] = 1; rp[1] = 1;
        reset_n    = 1'b0;
        chipselect = 2'b00;
        read_n     = 2'b11;
        write_n    = 2'b11;
        for (int d = 0; d < 2; d++) begin
            address[d]     = 2'd0;
            writedata[d]   = 32'd0;
            din[d]         = 16'd0;
            model_rdata[d] = 16'd0;
        end
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk_eq($sformatf("d%0d reset cs_n", d), 32'(cs_n[d]), 32'd1);
            chk_eq($sformatf("d%0d reset r_n", d), 32'(r_n[d]), 32'd1);
            chk_eq($sformatf("d%0d reset w_n", d), 32'(w_n[d]), 32'd1);
            chk_eq($sformatf("d%0d reset oe", d), 32'(oe[d]), 32'd0);
            chk_eq($sformatf("d%0d reset busy", d), 32'(busy[d]), 32'd0);
            chk_eq($sformatf("d%0d reset addr", d), 32'(hpi_addr[d]), 32'd0);
            chk_eq($sformatf("d%0d reset dout", d), 32'(dout[d]), 32'd0);
            chk_eq($sformatf("d%0d reset readdata", d), readdata[d], 32'd0);
        end
        reset_n = 1'b1;

        run_access(0, 1'b1, 1'b0, 2'd2, 32'h0000_1234, 1'b0, 16'h0000);
        idle_cycles(2);
        run_access(0, 1'b0, 1'b0, 2'd3, $urandom, 1'b1, 16'hBEEF);
        run_access(0, 1'b1, 1'b0, 2'd0, $urandom, 1'b0, 16'h0000);
        run_access(0, 1'b0, 1'b1, 2'd1, 32'hFFFF_C0DE, 1'b0, 16'h0000);
        run_access(0, 1'b1, 1'b0, 2'd2, 32'hDEAD_00A5, 1'b0, 16'h0000);
        run_access(0, 1'b0, 1'b0, 2'd3, $urandom, 1'b0, 16'h0000);
        idle_cycles(1);
        reset_mid_strobe();
        idle_cycles(1);
        run_access(0, 1'b1, 1'b0, 2'd2, $urandom, 1'b0, 16'h0000);
        run_access(1, 1'b0, 1'b0, 2'd3, $urandom, 1'b0, 16'h0000);
        run_access(1, 1'b1, 1'b0, 2'd1, $urandom, 1'b0, 16'h0000);

        for (int i = 0; i < 30; i++) begin
            run_access(int'($urandom_range(0, 1)), 1'($urandom), ($urandom_range(0, 3) == 0),
                       2'($urandom), $urandom, 1'b0, 16'h0000);
            idle_cycles(int'($urandom_range(0, 2)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/frogger_qsys_otg_hpi_ctrl.md
# frogger_qsys_otg_hpi_ctrl

Hardware sequencer for the CY7C67200 OTG host-port interface (HPI). It replaces software bit-banging of separate address/data/strobe PIOs with a single Avalon-MM slave. Each Avalon read or write becomes one fully timed HPI bus cycle, with programmable setup, strobe, hold and recovery phases. It sits between the Nios II data master and the OTG chip pins in the frogger_qsys system.

## Interface

Parameters (legal range 1..15; each phase counter is 4 bits):
- SETUP_CYCLES, 2, cycles with CS asserted and address/data driven before the strobe
- STROBE_CYCLES, 4, cycles with RD_N or WR_N low
- HOLD_CYCLES, 2, cycles after strobe release with CS, address and data still held
- RECOVER_CYCLES, 2, cycles with CS deasserted before the next access may begin

Ports:
- clk  in  1  system clock; all logic on its rising edge
- reset_n  in  1  asynchronous, active-low reset
- address  in  2  HPI register select: 0 DATA, 1 MAILBOX, 2 ADDRESS, 3 STATUS
- chipselect  in  1  Avalon slave select
- read_n  in  1  Avalon read request, active low
- write_n  in  1  Avalon write request, active low
- writedata  in  32  write data; bits [15:0] used, [31:16] ignored
- readdata  out  32  {16'b0, rdata_reg}
- waitrequest  out  1  Avalon stall
- busy  out  1  high whenever state != IDLE
- otg_hpi_address  out  2  HPI register select to the chip
- otg_hpi_cs_n  out  1  HPI chip select
- otg_hpi_r_n  out  1  HPI read strobe
- otg_hpi_w_n  out  1  HPI write strobe
- otg_hpi_data_out  out  16  HPI write data
- otg_hpi_data_oe  out  1  tristate enable for the data pins at top level
- otg_hpi_data_in  in  16  HPI read data from the pins

## Operation

- Request = chipselect & (~read_n | ~write_n).
- If both read_n and write_n are low, the access is a write.
- FSM states: IDLE, SETUP, STROBE, HOLD, RECOVER.
- Each timed state loads its 4-bit down-counter with N-1 on entry and exits when the counter reaches 0.
- IDLE, on request:
  - latch address, direction and writedata[15:0]
  - go to SETUP
- SETUP:
  - cs_n=0, address driven
  - for writes, data_out driven and oe=1
  - r_n=w_n=1
  - lasts SETUP_CYCLES
- STROBE:
  - as SETUP, plus r_n=0 (read) or w_n=0 (write)
  - lasts STROBE_CYCLES
  - on a read, otg_hpi_data_in is captured into rdata_reg on the edge that leaves STROBE
- HOLD:
  - strobes high; cs_n, address, data and oe unchanged
  - lasts HOLD_CYCLES
- RECOVER:
  - cs_n=1, oe=0
  - lasts RECOVER_CYCLES, then IDLE
  - new requests are not accepted until IDLE
- waitrequest = request & ~(state==HOLD & counter==0).
  - It is combinational and low only in the last HOLD cycle, which is the Avalon completion cycle.
  - It is low whenever there is no request.
- rdata_reg:
  - updated only by reads
  - writes leave it unchanged
  - readdata is valid in the read's completion cycle
- All HPI outputs are driven from registers, so there are no combinational glitches on the pins.
- If the master drops its request mid-transaction (protocol violation), the HPI cycle still runs to the end of RECOVER.
- Reset (asynchronous, any time, including mid-strobe):
  - state=IDLE, counters=0
  - cs_n=1, r_n=1, w_n=1, address=0, data_out=0, oe=0, rdata_reg=0, busy=0

## Timing

- Cycle 0 is the IDLE cycle in which the request is first seen, with waitrequest=1.
- SETUP occupies cycles 1..S, STROBE S+1..S+P, HOLD S+P+1..S+P+H, RECOVER the next R cycles. S, P, H and R are the four parameters.
- waitrequest is low in cycle S+P+H.
  - With defaults this is cycle 8, so the master holds the request for 9 cycles.
- Minimum spacing between successive cs_n falling edges is 1+S+P+H+R cycles (11 with defaults).
  - This assumes a back-to-back request is presented in the first IDLE cycle.
- Write data and address are stable from the first SETUP cycle through the last HOLD cycle, covering both strobe edges.
- The read capture edge is the edge ending the last STROBE cycle.

## Test plan

- Default parameters, write 0x0000_1234 to address 2:
  - cs_n low for exactly 8 cycles; w_n low for 4 cycles starting 2 cycles after cs_n falls
  - data_out=0x1234 with oe=1 throughout cs_n low
  - waitrequest low only in cycle 8; r_n stays 1
- Read address 3 with otg_hpi_data_in=0xBEEF during STROBE:
  - readdata=0x0000_BEEF in the completion cycle; oe stays 0
  - a following write leaves readdata at 0x0000_BEEF
- Back-to-back write then read, with the request re-presented immediately:
  - second cs_n falling edge exactly 11 cycles after the first
  - cs_n high for 2+ cycles in between; busy high continuously except in the IDLE cycles
- Both read_n and write_n low at address 1:
  - w_n strobes and r_n stays 1
- Assert reset_n low during the 2nd STROBE cycle of a write:
  - in the same cycle, w_n=1, cs_n=1, oe=0, busy=0
  - after release, the next request runs a full, correctly timed cycle
- Parameters S=1, P=1, H=1, R=1, read:
  - waitrequest low in cycle 3
  - r_n low exactly 1 cycle; cs_n low exactly 3 cycles
